// File: rtl/tanh_arb_pkg.sv
// tanh_arb_pkg
// Shared types and helpers for the tanh evaluation-unit arbiter.
//   ID_W     : requester id width, sized for the largest supported
//              requester count (8).
//   CODE_W   : working width for the saturation compare. It must be at
//              least the code width used by the top.
//   tag_t    : {vld, id} entry carried alongside a model evaluation.
//   sat_code : clamps a signed code to [-lim, +lim].
package tanh_arb_pkg;

  localparam int ID_W   = 3;
  localparam int CODE_W = 32;

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } tag_t;

  // Callers sign-extend the code to CODE_W first, so the comparison is a
  // full-width signed compare and never wraps.
  function automatic logic signed [CODE_W-1:0] sat_code(
    input logic signed [CODE_W-1:0] x,
    input logic signed [CODE_W-1:0] lim
  );
    if (x > lim) begin
      return lim;
    end else if (x < -lim) begin
      return -lim;
    end else begin
      return x;
    end
  endfunction

endpackage

// File: rtl/tanh_share_arb_rr_arbiter.sv
// rr_arbiter
// N-way round-robin arbiter. It grants the first requesting index at or
// after the pointer, wrapping modulo N.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_req      : request vector
//   i_advance  : grant was taken this cycle, so the pointer moves past it
//   o_grant    : one-hot grant, or zero when no request is present
//   o_idx      : binary index of the grant
module rr_arbiter
  import tanh_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    i_req,
  input  logic            i_advance,
  output logic [N-1:0]    o_grant,
  output logic [ID_W-1:0] o_idx
);

  logic [ID_W-1:0] r_ptr;
  logic [N-1:0]    w_mask;
  logic [N-1:0]    w_hi;
  logic [N-1:0]    w_pick;
  logic [N-1:0]    w_grant;
  logic [ID_W-1:0] w_idx;

  // Requests at or above the pointer take priority. If there are none,
  // the search wraps around to the lowest request overall.
  always_comb begin
    w_mask = '0;
    for (int k = 0; k < N; k++) begin
      w_mask[k] = (ID_W'(k) >= r_ptr);
    end
  end

  assign w_hi   = i_req & w_mask;
  assign w_pick = (|w_hi) ? w_hi : i_req;

  always_comb begin
    w_grant = '0;
    w_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_pick[k]) begin
        w_grant    = '0;
        w_grant[k] = 1'b1;
        w_idx      = ID_W'(k);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_advance) begin
      r_ptr <= (w_idx == ID_W'(N - 1)) ? '0 : w_idx + ID_W'(1);
    end
  end

  assign o_grant = w_grant;
  assign o_idx   = w_idx;

endmodule

// File: rtl/tanh_share_arb.sv
// tanh_share_arb
// Time-shares one pipelined fixed-point tanh model among N_REQ requesters.
// The arbiter accepts at most one request per cycle. The accepted request
// is saturated and issued to the model one cycle later. A tag pipe that
// runs alongside the model steers the result back to the requester that
// issued it.
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_valid/req_ready   : per-requester handshake (ready is one-hot or zero)
//   req_data              : requester i code at [i*WIDTH +: WIDTH]
//   resp_valid/resp_data  : one-cycle result pulse and shared result code
//   fn_in/fn_issue/fn_out : interface to the shared model (fn_out arrives
//                           LAT cycles after fn_issue)
//   busy                  : any request outstanding
module tanh_share_arb
  import tanh_arb_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int WIDTH  = 18,
  parameter int LAT    = 2,
  parameter int IN_LIM = 8191
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       resp_valid,
  output logic [WIDTH-1:0]       resp_data,
  output logic [WIDTH-1:0]       fn_in,
  output logic                   fn_issue,
  input  logic [WIDTH-1:0]       fn_out,
  output logic                   busy
);

  logic [N_REQ-1:0]        r_pending;
  logic [N_REQ-1:0]        r_resp_valid;
  logic [WIDTH-1:0]        r_resp_data;
  logic [WIDTH-1:0]        r_fn_in;
  tag_t                    r_issue_tag;

  logic [N_REQ-1:0]        w_elig;
  logic [N_REQ-1:0]        w_grant;
  logic [ID_W-1:0]         w_idx;
  logic                    w_accept;
  logic signed [WIDTH-1:0] w_sel_data;
  logic signed [WIDTH-1:0] w_sat;
  tag_t                    w_out_tag;
  logic [N_REQ-1:0]        w_clr;

  // A requester with a result still in flight is not eligible. This
  // limits each requester to one outstanding request.
  assign w_elig   = req_valid & ~r_pending;
  assign w_accept = |w_grant;

  rr_arbiter #(
    .N (N_REQ)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (w_elig),
    .i_advance (w_accept),
    .o_grant   (w_grant),
    .o_idx     (w_idx)
  );

  always_comb begin
    w_sel_data = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_grant[k]) begin
        w_sel_data = req_data[k*WIDTH +: WIDTH];
      end
    end
  end

  assign w_sat = WIDTH'(sat_code(CODE_W'(w_sel_data), CODE_W'(IN_LIM)));

  // Issue stage. The tag is registered together with fn_in, so the tag
  // pipe entry lines up with fn_issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fn_in     <= '0;
      r_issue_tag <= '0;
    end else begin
      r_issue_tag.vld <= w_accept;
      r_issue_tag.id  <= w_idx;
      if (w_accept) begin
        r_fn_in <= w_sat;
      end
    end
  end

  // The tag emerges in the same cycle that fn_out becomes valid. With
  // LAT=0 the model is combinational, so the issue tag is used directly.
  generate
    if (LAT == 0) begin : g_tag_comb
      assign w_out_tag = r_issue_tag;
    end else begin : g_tag_pipe
      tag_t r_tag_pipe [LAT];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < LAT; k++) begin
            r_tag_pipe[k] <= '0;
          end
        end else begin
          r_tag_pipe[0] <= r_issue_tag;
          for (int k = 1; k < LAT; k++) begin
            r_tag_pipe[k] <= r_tag_pipe[k-1];
          end
        end
      end

      assign w_out_tag = r_tag_pipe[LAT-1];
    end
  endgenerate

  always_comb begin
    w_clr = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_clr[k] = w_out_tag.vld && (w_out_tag.id == ID_W'(k));
    end
  end

  // A pending bit clears on the same edge that raises its resp_valid, so
  // the requester can be granted again in its response cycle. A clear and
  // a grant always target different requesters, because a pending
  // requester is never eligible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending    <= '0;
      r_resp_valid <= '0;
      r_resp_data  <= '0;
    end else begin
      r_pending    <= (r_pending & ~w_clr) | w_grant;
      r_resp_valid <= w_clr;
      if (w_out_tag.vld) begin
        r_resp_data <= fn_out;
      end
    end
  end

  assign req_ready  = w_grant;
  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;
  assign fn_in      = r_fn_in;
  assign fn_issue   = r_issue_tag.vld;
  assign busy       = |r_pending;

endmodule

// File: tb/tb_tanh_share_arb.sv
// tb_tanh_share_arb
// Directed bench for tanh_share_arb. Instance A uses LAT=2 and instance
// B uses LAT=0. Each model is a LAT-deep pipe that returns fn_in + 1.
module tb_tanh_share_arb;

  logic               clk;
  logic               rst_n;

  logic [3:0]         reqValid;
  logic [3:0]         reqReady;
  logic [71:0]        reqData;
  logic [3:0]         respValid;
  logic signed [17:0] respData;
  logic signed [17:0] fnIn;
  logic               fnIssue;
  logic signed [17:0] fnOut;
  logic               busy;
  logic signed [17:0] pipe1;
  logic signed [17:0] pipe2;

  logic [3:0]         reqValidB;
  logic [3:0]         reqReadyB;
  logic [71:0]        reqDataB;
  logic [3:0]         respValidB;
  logic signed [17:0] respDataB;
  logic signed [17:0] fnInB;
  logic               fnIssueB;
  logic signed [17:0] fnOutB;
  logic               busyB;

  int tests;
  int fails;

  tanh_share_arb #(.N_REQ(4), .WIDTH(18), .LAT(2), .IN_LIM(8191)) dutA (
    .clk(clk), .rst_n(rst_n),
    .req_valid(reqValid), .req_ready(reqReady), .req_data(reqData),
    .resp_valid(respValid), .resp_data(respData),
    .fn_in(fnIn), .fn_issue(fnIssue), .fn_out(fnOut), .busy(busy)
  );

  tanh_share_arb #(.N_REQ(4), .WIDTH(18), .LAT(0), .IN_LIM(8191)) dutB (
    .clk(clk), .rst_n(rst_n),
    .req_valid(reqValidB), .req_ready(reqReadyB), .req_data(reqDataB),
    .resp_valid(respValidB), .resp_data(respDataB),
    .fn_in(fnInB), .fn_issue(fnIssueB), .fn_out(fnOutB), .busy(busyB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model for instance A: a two-register pipe that returns fn_in + 1.
  always @(posedge clk) begin
    pipe1 <= fnIn + 18'sd1;
    pipe2 <= pipe1;
  end
  assign fnOut  = pipe2;
  assign fnOutB = fnInB + 18'sd1;

  task automatic checkOutput(input string tag, input longint obs, input longint exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic applyStimulus(input int idx, input int val);
    reqData[idx*18 +: 18] = 18'(val);
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    rst_n     = 1'b0;
    reqValid  = '0;
    reqData   = '0;
    reqValidB = '0;
    reqDataB  = '0;

    // Reset state.
    #12;
    checkOutput("rst_ready", reqReady, 0);
    checkOutput("rst_resp_valid", respValid, 0);
    checkOutput("rst_resp_data", respData, 0);
    checkOutput("rst_fn_in", fnIn, 0);
    checkOutput("rst_fn_issue", fnIssue, 0);
    checkOutput("rst_busy", busy, 0);
    #10;
    rst_n = 1'b1;

    // Single request: requester 1, data 100, pointer starts at 0.
    nextCycle(); applyStimulus(1, 100); reqValid = 4'b0010; settle();
    checkOutput("single_ready", reqReady, 4'b0010);
    nextCycle(); reqValid = 4'b0000; settle();
    checkOutput("single_issue", fnIssue, 1);
    checkOutput("single_fn_in", fnIn, 100);
    checkOutput("single_busy_t1", busy, 1);
    checkOutput("single_ready_off", reqReady, 0);
    nextCycle(); settle();
    checkOutput("single_busy_t2", busy, 1);
    checkOutput("single_resp_t2", respValid, 0);
    nextCycle(); settle();
    checkOutput("single_busy_t3", busy, 1);
    checkOutput("single_resp_t3", respValid, 0);
    nextCycle(); settle();
    checkOutput("single_resp_t4", respValid, 4'b0010);
    checkOutput("single_data_t4", respData, 101);
    checkOutput("single_busy_t4", busy, 0);
    nextCycle(); settle();
    checkOutput("single_resp_t5", respValid, 0);
    checkOutput("single_data_hold", respData, 101);

    // Saturation. The pointer is now 2, and the requests are taken in
    // the order 2, 3, 0.
    nextCycle(); applyStimulus(2, 20000); reqValid = 4'b0100; settle();
    checkOutput("sat_ready2", reqReady, 4'b0100);
    nextCycle(); applyStimulus(3, -20000); reqValid = 4'b1000; settle();
    checkOutput("sat_fn_in_pos", fnIn, 8191);
    checkOutput("sat_ready3", reqReady, 4'b1000);
    nextCycle(); applyStimulus(0, -8191); reqValid = 4'b0001; settle();
    checkOutput("sat_fn_in_neg", fnIn, -8191);
    checkOutput("sat_ready0", reqReady, 4'b0001);
    nextCycle(); reqValid = 4'b0000; settle();
    checkOutput("sat_fn_in_edge", fnIn, -8191);
    nextCycle(); settle();
    checkOutput("sat_resp2", respValid, 4'b0100);
    checkOutput("sat_data2", respData, 8192);
    nextCycle(); settle();
    checkOutput("sat_resp3", respValid, 4'b1000);
    checkOutput("sat_data3", respData, -8190);
    nextCycle(); settle();
    checkOutput("sat_resp0", respValid, 4'b0001);
    checkOutput("sat_data0", respData, -8190);
    nextCycle(); settle();
    checkOutput("sat_idle_resp", respValid, 0);
    checkOutput("sat_idle_busy", busy, 0);

    // Reset mid-flight. Requester 1 is granted with the pointer at 1, and
    // the pointer then moves to 2.
    nextCycle(); applyStimulus(1, 50); reqValid = 4'b0010; settle();
    checkOutput("mid_ready", reqReady, 4'b0010);
    nextCycle(); reqValid = 4'b0000; settle();
    checkOutput("mid_issue", fnIssue, 1);
    checkOutput("mid_fn_in", fnIn, 50);
    nextCycle(); settle();
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_resp", respValid, 0);
    checkOutput("mid_rst_data", respData, 0);
    checkOutput("mid_rst_fn_in", fnIn, 0);
    checkOutput("mid_rst_issue", fnIssue, 0);
    checkOutput("mid_rst_busy", busy, 0);
    nextCycle(); rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      nextCycle(); settle();
      checkOutput("mid_no_resp", respValid, 0);
    end
    // With the pointer back at 0, requester 1 wins over requester 3.
    nextCycle(); applyStimulus(1, 200); applyStimulus(3, 300); reqValid = 4'b1010; settle();
    checkOutput("post_rst_ready1", reqReady, 4'b0010);
    nextCycle(); settle();
    checkOutput("post_rst_ready3", reqReady, 4'b1000);
    nextCycle(); reqValid = 4'b0000; settle();
    checkOutput("post_rst_ready_off", reqReady, 0);
    nextCycle(); settle();
    nextCycle(); settle();
    checkOutput("post_rst_resp1", respValid, 4'b0010);
    checkOutput("post_rst_data1", respData, 201);
    nextCycle(); settle();
    checkOutput("post_rst_resp3", respValid, 4'b1000);
    checkOutput("post_rst_data3", respData, 301);
    nextCycle(); settle();
    checkOutput("post_rst_busy", busy, 0);

    // Withdraw. The pointer is 0, so requester 0 wins and requester 3
    // then drops its request.
    nextCycle(); applyStimulus(0, 7); applyStimulus(3, 9); reqValid = 4'b1001; settle();
    checkOutput("wd_ready0", reqReady, 4'b0001);
    for (int k = 1; k <= 6; k++) begin
      nextCycle(); reqValid = 4'b0000; settle();
      checkOutput("wd_ready_none", reqReady, 0);
      checkOutput("wd_resp", respValid, (k == 4) ? 4'b0001 : 4'b0000);
      if (k == 4) checkOutput("wd_data", respData, 8);
    end
    checkOutput("wd_busy", busy, 0);

    // Round robin, starting from reset with all requesters valid.
    nextCycle(); rst_n = 1'b0; #1; rst_n = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(i, 10 * i);
    reqValid = 4'b1111;
    for (int k = 0; k < 12; k++) begin
      if (k != 0) nextCycle();
      settle();
      checkOutput("rr_ready", reqReady, longint'(1) << (k % 4));
      checkOutput("rr_resp", respValid, (k >= 4) ? (longint'(1) << ((k - 4) % 4)) : 0);
      if (k >= 4) checkOutput("rr_data", respData, 10 * ((k - 4) % 4) + 1);
    end
    nextCycle(); reqValid = 4'b0000;
    repeat (6) nextCycle();
    settle();
    checkOutput("rr_drain_busy", busy, 0);

    // One outstanding request per requester: requester 2 holds valid on
    // both instances. It is re-granted every 4 cycles at LAT=2 and every
    // 2 cycles at LAT=0.
    nextCycle();
    applyStimulus(2, 5);
    reqValid  = 4'b0100;
    reqDataB[2*18 +: 18] = 18'(20000);
    reqValidB = 4'b0100;
    for (int k = 0; k < 12; k++) begin
      if (k != 0) nextCycle();
      settle();
      checkOutput("hold_ready_lat2", reqReady, (k % 4 == 0) ? 4'b0100 : 4'b0000);
      checkOutput("hold_resp_lat2", respValid, (k >= 4 && k % 4 == 0) ? 4'b0100 : 4'b0000);
      checkOutput("hold_ready_lat0", reqReadyB, (k % 2 == 0) ? 4'b0100 : 4'b0000);
      checkOutput("hold_resp_lat0", respValidB, (k >= 2 && k % 2 == 0) ? 4'b0100 : 4'b0000);
      if (k >= 2 && k % 2 == 0) checkOutput("hold_data_lat0", respDataB, 8192);
      if (k >= 4 && k % 4 == 0) checkOutput("hold_data_lat2", respData, 6);
    end
    reqValid  = 4'b0000;
    reqValidB = 4'b0000;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
